// File: rtl/traffic_ctrl_param.sv
// Four-approach intersection controller with timed phases and on-demand left turns.
// It latches pedestrian requests, drives the walk heads and shows a per-phase countdown.
module traffic_ctrl_param #(
  parameter int TICK_DIV = 100_000_000,
  parameter int GREEN_T  = 10,
  parameter int LEFT_T   = 5,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 6,
  parameter int FLASH_T  = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             car_left_n,
  input  logic             car_left_e,
  input  logic             ped_req_n,
  input  logic             ped_req_e,
  output logic [2:0]       north_lights,
  output logic [2:0]       north_left_lights,
  output logic [2:0]       east_lights,
  output logic [2:0]       east_left_lights,
  output logic [2:0]       walk_north,
  output logic [2:0]       walk_east,
  output logic [3:0]       phase,
  output logic [CNT_W-1:0] countdown
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [3:0] {
    NS_ALLRED = 4'd0, NS_LEFT_G = 4'd1, NS_LEFT_Y = 4'd2, NS_G = 4'd3, NS_Y = 4'd4,
    EW_ALLRED = 4'd5, EW_LEFT_G = 4'd6, EW_LEFT_Y = 4'd7, EW_G = 4'd8, EW_Y = 4'd9
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             left_n_q, left_n_d, left_e_q, left_e_d;
  logic             ped_n_q, ped_n_d, ped_e_q, ped_e_d;
  logic             walk_act_n_q, walk_act_n_d, walk_act_e_q, walk_act_e_d;
  logic [2:0]       north_q, north_d, north_left_q, north_left_d;
  logic [2:0]       east_q, east_d, east_left_q, east_left_d;
  logic [2:0]       walk_n_q, walk_n_d, walk_e_q, walk_e_d;
  logic [3:0]       phase_q, phase_d;
  logic [CNT_W-1:0] countdown_q, countdown_d;
  logic             tick_s, adv_s, changed_s;

  function automatic logic [CNT_W-1:0] dur_of(input state_e s);
    logic [CNT_W-1:0] d;
    case (s)
      NS_ALLRED, EW_ALLRED:             d = CNT_W'(ALLRED_T);
      NS_LEFT_G, EW_LEFT_G:             d = CNT_W'(LEFT_T);
      NS_LEFT_Y, EW_LEFT_Y, NS_Y, EW_Y: d = CNT_W'(YELLOW_T);
      NS_G, EW_G:                       d = CNT_W'(GREEN_T);
      default:                          d = CNT_W'(ALLRED_T);
    endcase
    return d;
  endfunction

  function automatic logic [2:0] head(input state_e s, input state_e g, input state_e y);
    logic [2:0] h;
    if (s == g) begin
      h = 3'b001;
    end else if (s == y) begin
      h = 3'b010;
    end else begin
      h = 3'b100;
    end
    return h;
  endfunction

  // Ticks elapsed in green follow from the down-counting timer, so no second counter is needed.
  function automatic logic [2:0] walk_head(input logic act, input logic [CNT_W-1:0] timer);
    logic [CNT_W-1:0] el;
    logic [2:0]       h;
    el = CNT_W'(GREEN_T - 1) - timer;
    if (!act) begin
      h = 3'b100;
    end else if (el < CNT_W'(WALK_T)) begin
      h = 3'b001;
    end else if (el < CNT_W'(WALK_T + FLASH_T)) begin
      h = 3'b010;
    end else begin
      h = 3'b100;
    end
    return h;
  endfunction

  // Next-state, timing, request latches and registered output decode
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    timer_d      = timer_q;
    tick_s       = (presc_q == PRESC_MAX);
    adv_s        = tick_s && (timer_q == {CNT_W{1'b0}});
    case (state_q)
      NS_ALLRED: begin
        if (adv_s) begin
          state_d = left_n_q ? NS_LEFT_G : NS_G;
        end else begin
          state_d = state_q;
        end
      end
      NS_LEFT_G: state_d = adv_s ? NS_LEFT_Y : state_q;
      NS_LEFT_Y: state_d = adv_s ? NS_G      : state_q;
      NS_G:      state_d = adv_s ? NS_Y      : state_q;
      NS_Y:      state_d = adv_s ? EW_ALLRED : state_q;
      EW_ALLRED: begin
        if (adv_s) begin
          state_d = left_e_q ? EW_LEFT_G : EW_G;
        end else begin
          state_d = state_q;
        end
      end
      EW_LEFT_G: state_d = adv_s ? EW_LEFT_Y : state_q;
      EW_LEFT_Y: state_d = adv_s ? EW_G      : state_q;
      EW_G:      state_d = adv_s ? EW_Y      : state_q;
      EW_Y:      state_d = adv_s ? NS_ALLRED : state_q;
      default:   state_d = NS_ALLRED;
    endcase

    changed_s = (state_d != state_q);
    if (changed_s) begin
      presc_d = {PW{1'b0}};
      timer_d = dur_of(state_d) - CNT_W'(1);
    end else if (tick_s) begin
      presc_d = {PW{1'b0}};
      timer_d = timer_q - CNT_W'(1);
    end else begin
      presc_d = presc_q + PW'(1);
      timer_d = timer_q;
    end

    // Clear wins over a simultaneous sensor set; a held sensor re-latches next clock.
    if (changed_s && (state_d == NS_LEFT_G)) begin
      left_n_d = 1'b0;
    end else begin
      left_n_d = left_n_q | car_left_n;
    end
    if (changed_s && (state_d == EW_LEFT_G)) begin
      left_e_d = 1'b0;
    end else begin
      left_e_d = left_e_q | car_left_e;
    end

    if (changed_s && (state_d == NS_G)) begin
      ped_n_d      = 1'b0;
      walk_act_n_d = ped_n_q | ped_req_n;
    end else begin
      ped_n_d      = ped_n_q | ped_req_n;
      walk_act_n_d = (state_d == NS_G) ? walk_act_n_q : 1'b0;
    end
    if (changed_s && (state_d == EW_G)) begin
      ped_e_d      = 1'b0;
      walk_act_e_d = ped_e_q | ped_req_e;
    end else begin
      ped_e_d      = ped_e_q | ped_req_e;
      walk_act_e_d = (state_d == EW_G) ? walk_act_e_q : 1'b0;
    end

    north_d      = head(state_d, NS_G, NS_Y);
    north_left_d = head(state_d, NS_LEFT_G, NS_LEFT_Y);
    east_d       = head(state_d, EW_G, EW_Y);
    east_left_d  = head(state_d, EW_LEFT_G, EW_LEFT_Y);
    walk_n_d     = walk_head(walk_act_n_d && (state_d == NS_G), timer_d);
    walk_e_d     = walk_head(walk_act_e_d && (state_d == EW_G), timer_d);
    phase_d      = state_d;
    countdown_d  = timer_d + CNT_W'(1);
  end

  // State, timing and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= NS_ALLRED;
      presc_q      <= {PW{1'b0}};
      timer_q      <= CNT_W'(ALLRED_T - 1);
      left_n_q     <= 1'b0;
      left_e_q     <= 1'b0;
      ped_n_q      <= 1'b0;
      ped_e_q      <= 1'b0;
      walk_act_n_q <= 1'b0;
      walk_act_e_q <= 1'b0;
      north_q      <= 3'b100;
      north_left_q <= 3'b100;
      east_q       <= 3'b100;
      east_left_q  <= 3'b100;
      walk_n_q     <= 3'b100;
      walk_e_q     <= 3'b100;
      phase_q      <= 4'd0;
      countdown_q  <= CNT_W'(ALLRED_T);
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      timer_q      <= timer_d;
      left_n_q     <= left_n_d;
      left_e_q     <= left_e_d;
      ped_n_q      <= ped_n_d;
      ped_e_q      <= ped_e_d;
      walk_act_n_q <= walk_act_n_d;
      walk_act_e_q <= walk_act_e_d;
      north_q      <= north_d;
      north_left_q <= north_left_d;
      east_q       <= east_d;
      east_left_q  <= east_left_d;
      walk_n_q     <= walk_n_d;
      walk_e_q     <= walk_e_d;
      phase_q      <= phase_d;
      countdown_q  <= countdown_d;
    end
  end

  assign north_lights      = north_q;
  assign north_left_lights = north_left_q;
  assign east_lights       = east_q;
  assign east_left_lights  = east_left_q;
  assign walk_north        = walk_n_q;
  assign walk_east         = walk_e_q;
  assign phase             = phase_q;
  assign countdown         = countdown_q;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Scoreboard bench for traffic_ctrl_param: a clock-counting reference model pushes the
// expected outputs every cycle and a monitor on the falling edge compares them.
module tb_traffic_ctrl_param;

  localparam int TD = 4, GT = 10, LT = 5, YT = 3, AT = 1, WT = 6, FT = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       car_left_n = 1'b0, car_left_e = 1'b0, ped_req_n = 1'b0, ped_req_e = 1'b0;
  logic [2:0] north_lights, north_left_lights, east_lights, east_left_lights;
  logic [2:0] walk_north, walk_east;
  logic [3:0] phase;
  logic [7:0] countdown;

  traffic_ctrl_param #(
    .TICK_DIV(TD), .GREEN_T(GT), .LEFT_T(LT), .YELLOW_T(YT),
    .ALLRED_T(AT), .WALK_T(WT), .FLASH_T(FT), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .car_left_n(car_left_n), .car_left_e(car_left_e),
    .ped_req_n(ped_req_n), .ped_req_e(ped_req_e),
    .north_lights(north_lights), .north_left_lights(north_left_lights),
    .east_lights(east_lights), .east_left_lights(east_left_lights),
    .walk_north(walk_north), .walk_east(walk_east),
    .phase(phase), .countdown(countdown)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] nl, nll, el, ell, wn, we;
    logic [3:0] ph;
    logic [7:0] cd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: phase number, clocks spent in it, and request/walk flags per direction (0=N,1=E)
  int m_ph, m_clk;
  bit m_lreq[2], m_preq[2], m_walk[2];

  function automatic int dur_ticks(input int p);
    case (p)
      0, 5:       return AT;
      1, 6:       return LT;
      3, 8:       return GT;
      default:    return YT;
    endcase
  endfunction

  function automatic int succ(input int p);
    case (p)
      0:       return m_lreq[0] ? 1 : 3;
      5:       return m_lreq[1] ? 6 : 8;
      9:       return 0;
      default: return p + 1;
    endcase
  endfunction

  function automatic void model_reset();
    m_ph = 0; m_clk = 0;
    for (int d = 0; d < 2; d++) begin
      m_lreq[d] = 0; m_preq[d] = 0; m_walk[d] = 0;
    end
  endfunction

  function automatic void model_step(input bit [1:0] car, input bit [1:0] ped);
    int nxt;
    bit entered;
    nxt = m_ph;
    if (m_clk + 1 == dur_ticks(m_ph) * TD) begin
      nxt = succ(m_ph);
      m_clk = 0;
    end else begin
      m_clk = m_clk + 1;
    end
    entered = (nxt != m_ph);
    for (int d = 0; d < 2; d++) begin
      int lg, g;
      lg = d ? 6 : 1;
      g  = d ? 8 : 3;
      if (entered && nxt == lg) m_lreq[d] = 0;
      else m_lreq[d] = m_lreq[d] | car[d];
      if (entered && nxt == g) begin
        m_walk[d] = m_preq[d] | ped[d];
        m_preq[d] = 0;
      end else begin
        m_preq[d] = m_preq[d] | ped[d];
        if (nxt != g) m_walk[d] = 0;
      end
    end
    m_ph = nxt;
  endfunction

  function automatic logic [2:0] walk_val(input bit act, input int t);
    if (!act) return 3'b100;
    if (t < WT) return 3'b001;
    if (t < WT + FT) return 3'b010;
    return 3'b100;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int t;
    t = m_clk / TD;
    e.nl  = (m_ph == 3) ? 3'b001 : (m_ph == 4) ? 3'b010 : 3'b100;
    e.nll = (m_ph == 1) ? 3'b001 : (m_ph == 2) ? 3'b010 : 3'b100;
    e.el  = (m_ph == 8) ? 3'b001 : (m_ph == 9) ? 3'b010 : 3'b100;
    e.ell = (m_ph == 6) ? 3'b001 : (m_ph == 7) ? 3'b010 : 3'b100;
    e.wn  = walk_val(m_walk[0] && m_ph == 3, t);
    e.we  = walk_val(m_walk[1] && m_ph == 8, t);
    e.ph  = 4'(m_ph);
    e.cd  = 8'(dur_ticks(m_ph) - t);
    return e;
  endfunction

  function automatic exp_t dut_out();
    exp_t g;
    g = {north_lights, north_left_lights, east_lights, east_left_lights,
         walk_north, walk_east, phase, countdown};
    return g;
  endfunction

  // Monitor: compare each cycle's DUT outputs against the queued expectation
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e, g;
      e = q.pop_front();
      g = dut_out();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL outputs cycle %0d got nl=%b nll=%b el=%b ell=%b wn=%b we=%b ph=%0d cd=%0d exp nl=%b nll=%b el=%b ell=%b wn=%b we=%b ph=%0d cd=%0d",
                 cyc, g.nl, g.nll, g.el, g.ell, g.wn, g.we, g.ph, g.cd,
                 e.nl, e.nll, e.el, e.ell, e.wn, e.we, e.ph, e.cd);
      end
    end
  end

  task automatic step(input bit [1:0] car, input bit [1:0] ped);
    car_left_n = car[0]; car_left_e = car[1];
    ped_req_n  = ped[0]; ped_req_e  = ped[1];
    @(posedge clk);
    #1;
    cyc++;
    if (!reset) model_reset();
    else model_step(car, ped);
    q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00);
  endtask

  task automatic run_until(input int ph, input string name);
    int n;
    n = 0;
    while (m_ph != ph && n < 300) begin
      step(2'b00, 2'b00);
      n++;
    end
    if (m_ph != ph) begin
      checks++;
      errors++;
      $display("FAIL wait_%s phase %0d got model phase %0d after %0d cycles", name, ph, m_ph, n);
    end
  endtask

  initial begin
    exp_t r, g;
    model_reset();
    r = model_out();

    // Power-on reset then idle cycling
    idle(3);
    reset = 1'b1;
    idle(230);

    // Left-turn demand from north while east has green
    run_until(8, "ew_g");
    idle(5);
    step(2'b01, 2'b00);
    idle(300);

    // East pedestrian request during north green
    run_until(3, "ns_g_a");
    idle(7);
    step(2'b00, 2'b10);
    idle(250);

    // North pedestrian request during its own green
    run_until(3, "ns_g_b");
    idle(15);
    step(2'b00, 2'b01);
    idle(300);

    // Asynchronous reset mid-NS_Y with latches set
    run_until(3, "ns_g_c");
    idle(3);
    step(2'b10, 2'b11);
    step(2'b01, 2'b00);
    run_until(4, "ns_y");
    idle(5);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    g = dut_out();
    checks++;
    if (g !== r) begin
      errors++;
      $display("FAIL async_reset got %h exp %h", g, r);
    end
    idle(2);
    reset = 1'b1;
    idle(250);

    // Random sensor and button activity
    for (int i = 0; i < 3000; i++) begin
      bit [1:0] car, ped;
      car[0] = ($urandom_range(0, 59) == 0);
      car[1] = ($urandom_range(0, 59) == 0);
      ped[0] = ($urandom_range(0, 79) == 0);
      ped[1] = ($urandom_range(0, 79) == 0);
      step(car, ped);
    end

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
